// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single write port of an async FIFO among
// NUM_SRC packet sources in the write clock domain. A grant is held for a whole
// packet, from its first beat through the beat with last set. Arbitration takes
// one IDLE cycle per packet. Back-pressure comes from the synchronized FIFO
// full flag.
//
// Optional feature (compile-time macro FIFO_WR_ARB_SRC_TAG_EN):
//   defined   : fifo_wr_data_o = {gnt_idx, data}, DATA_WIDTH+IDX_WIDTH wide
//   undefined : fifo_wr_data_o = data, DATA_WIDTH wide
//
// Ports:
//   clk_i          write-domain clock
//   rst_i          synchronous active-high reset
//   src_valid_i    per-source beat valid
//   src_last_i     per-source end-of-packet flag (qualified by valid)
//   src_data_i     per-source data, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   src_ready_o    per-source beat accepted
//   fifo_full_i    FIFO full flag (already synchronized)
//   fifo_wr_en_o   FIFO write enable
//   fifo_wr_data_o FIFO write data (optionally tagged with source index)
//   busy_o         a packet grant is active
//   gnt_idx_o      index of the currently granted source
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  input  logic [NUM_SRC-1:0]              src_last_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  input  logic                            fifo_full_i,
  output logic                            fifo_wr_en_o,
`ifdef FIFO_WR_ARB_SRC_TAG_EN
  output logic [DATA_WIDTH+IDX_WIDTH-1:0] fifo_wr_data_o,
`else
  output logic [DATA_WIDTH-1:0]           fifo_wr_data_o,
`endif
  output logic                            busy_o,
  output logic [IDX_WIDTH-1:0]            gnt_idx_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0]   gnt_idx_q, gnt_idx_d;

  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   accept;
  logic [IDX_WIDTH-1:0]   pick_idx;
  int                     cand;

  // Mux of the granted source's handshake and data.
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (gnt_idx_q == IDX_WIDTH'(k)) begin
        sel_valid = src_valid_i[k];
        sel_last  = src_last_i[k];
        sel_data  = src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin pick: scan offsets from the highest down so the source
  // nearest to rr_ptr (offset 0) is the last writer and therefore wins.
  always_comb begin
    pick_idx = rr_ptr_q;
    cand     = 0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (src_valid_i[cand]) pick_idx = IDX_WIDTH'(cand);
    end
  end

  // Handshake outputs are combinational from the inputs; reset blocks any
  // write in the cycle it is asserted.
  always_comb begin
    accept      = (state_q == BUSY) && sel_valid && !fifo_full_i && !rst_i;
    src_ready_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if ((state_q == BUSY) && (gnt_idx_q == IDX_WIDTH'(k)))
        src_ready_o[k] = !fifo_full_i && !rst_i;
    end
  end

  assign fifo_wr_en_o = accept;
  assign busy_o       = (state_q == BUSY);
  assign gnt_idx_o    = gnt_idx_q;

`ifdef FIFO_WR_ARB_SRC_TAG_EN
  assign fifo_wr_data_o = {gnt_idx_q, sel_data};
`else
  assign fifo_wr_data_o = sel_data;
`endif

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    unique case (state_q)
      IDLE: begin
        if (|src_valid_i) begin
          gnt_idx_d = pick_idx;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = (int'(gnt_idx_q) == NUM_SRC - 1) ? '0 : gnt_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

endmodule
